// File: rtl/pattern_scan_master_pkg.sv
// Shared constants and state encoding for the pattern-buffer scan interface.
// The buffers block uses the same buffer geometry and address width, so the
// master and the far end always agree on chain length and select range.
package pattern_scan_master_pkg;

  localparam int BUFFER_SIZE  = 22;  // bytes per pattern buffer
  localparam int BUFFER_WIDTH = 8;   // bits per byte
  localparam int NO_BUFS      = 8;   // addressable buffers
  localparam int SADDR_W      = $clog2(NO_BUFS);  // 3-bit scan address

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/pattern_scan_master_shifter.sv
// scan_byte_shifter: one byte worth of scan datapath.
//   clk, rst   : clock / async active-high reset
//   load       : parallel-load load_data into the transmit shift register
//   load_data  : byte to send, MSB first
//   shift      : chain shifts this edge; advance tx, capture sout, count bit
//   sout       : bit leaving the selected chain
//   tx_bit     : current transmit bit (tx MSB)
//   byte_out   : captured byte including the bit on sout this cycle
//   last       : this shift edge moves the final bit of the byte
module scan_byte_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         sout,
  output logic         tx_bit,
  output logic [W-1:0] byte_out,
  output logic         last
);

  localparam int BTW = $clog2(W);

  logic [W-1:0]   tx_q;
  logic [W-2:0]   cap_q;   // bits already captured; sout supplies the newest
  logic [BTW-1:0] bit_cnt;

  assign tx_bit   = tx_q[W-1];
  assign byte_out = {cap_q, sout};
  assign last     = shift && (bit_cnt == BTW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q    <= '0;
      cap_q   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      tx_q    <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      tx_q    <= {tx_q[W-2:0], 1'b0};
      cap_q   <= byte_out[W-2:0];
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_scan_master.sv
// pattern_scan_master: host-side driver of the pattern-buffer scan chain.
// Streams buffer_size bytes into the chain selected by addr and returns the
// bytes pushed out of that chain as a readback stream.
//   clk, rst          : clock / async active-high reset
//   start, addr       : begin a load of buffer addr (only seen in IDLE)
//   busy, done        : load in progress / one-cycle completion pulse
//   in_data/valid/ready   : byte stream into the chain
//   out_data/valid/ready  : readback byte stream (single-entry register)
//   sin, ssel, saddr  : scan data, scan enable, buffer select
//   sout              : scan data returning from the selected chain
module pattern_scan_master
  import pattern_scan_master_pkg::*;
#(
  parameter int buffer_size  = BUFFER_SIZE,
  parameter int buffer_width = BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SADDR_W-1:0]      addr,
  output logic                    busy,
  output logic                    done,
  input  logic [buffer_width-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [buffer_width-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sin,
  output logic                    ssel,
  output logic [SADDR_W-1:0]      saddr,
  input  logic                    sout
);

  localparam int BCW = $clog2(buffer_size + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(buffer_size - 1);

  scan_state_e state_q, state_d;
  logic [BCW-1:0] byte_cnt;

  logic                    load, shift, last, tx_bit;
  logic [buffer_width-1:0] byte_out;
  logic                    drain_ok;

  // The readback register is free (or frees this edge). A new byte may only
  // start shifting when this holds, so the 8-cycle shift can never land on
  // an undrained byte.
  assign drain_ok = !out_valid || out_ready;

  scan_byte_shifter #(.W(buffer_width)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (in_data),
    .shift     (shift),
    .sout      (sout),
    .tx_bit    (tx_bit),
    .byte_out  (byte_out),
    .last      (last)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        in_ready = drain_ok;
        if (in_valid && drain_ok) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (last) state_d = (byte_cnt == LAST_BYTE) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: if (drain_ok) begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan outputs are decoded from the state register so an async reset
  // drops ssel in the same cycle.
  assign busy = (state_q != ST_IDLE);
  assign ssel = shift;
  assign sin  = shift & tx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      saddr     <= '0;
      byte_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        saddr    <= addr;
        byte_cnt <= '0;
      end
      if (last) byte_cnt <= byte_cnt + 1'b1;
      // A landing byte takes priority; it can only land when the register
      // was already empty, so nothing is overwritten.
      if (last) begin
        out_data  <= byte_out;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_master.sv
module tb_pattern_scan_master;
  localparam int BS = 22, BW = 8, NB = 8, CL = BS * BW;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready, sout;
  logic [2:0] addr, saddr;
  logic busy, done, in_ready, out_valid, sin, ssel;
  logic [BW-1:0] in_data, out_data;

  pattern_scan_master dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Far end: one 176-bit chain per buffer; top bit leaves on sout.
  logic [CL-1:0] chains [NB];
  logic [CL-1:0] init_bits [NB];
  logic load_chains = 1'b0;
  always @(posedge clk) begin
    if (load_chains) begin
      for (int b = 0; b < NB; b++) chains[b] <= init_bits[b];
    end else if (ssel) begin
      chains[saddr] <= {chains[saddr][CL-2:0], sin};
    end
  end
  assign sout = chains[saddr][CL-1];

  // Monitor, sampled on the falling edge.
  int ssel_cnt = 0, burst_cnt = 0, burst_err = 0, saddr_err = 0;
  int stall_err = 0, sin_err = 0, done_cnt = 0, run = 0;
  logic [2:0] exp_saddr = 3'd0;
  logic [BW-1:0] rd_q [$];
  always @(negedge clk) begin
    if (rst) run <= 0;
    else begin
      if (ssel) begin
        ssel_cnt <= ssel_cnt + 1;
        run <= run + 1;
        if (saddr !== exp_saddr) saddr_err <= saddr_err + 1;
      end else if (run != 0) begin
        burst_cnt <= burst_cnt + 1;
        if (run != BW) burst_err <= burst_err + 1;
        run <= 0;
      end
      if (out_valid && out_ready) rd_q.push_back(out_data);
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && !out_ready && (in_ready || ssel)) stall_err <= stall_err + 1;
      if (!ssel && sin) sin_err <= sin_err + 1;
    end
  end

  // Reference model: buffer contents as byte arrays.
  logic [BW-1:0] ref_mem [NB][BS];
  bit known [NB];
  logic [BW-1:0] pat [BS];
  logic [BW-1:0] exp_rd [BS];

  int tests = 0, failed = 0;
  int r_ssel, r_bursts, r_berr, r_serr, r_stall, r_sinerr, r_done, r_base_rd, r_win_ssel;
  bit r_to, abort;
  logic r_rst_ssel, r_rst_busy, r_rst_ov;

  task automatic do_load(input logic [2:0] a, input int in_stall_byte, input int oready_after,
                         input int oready_len, input bit spurious, input int abort_bits);
    int b_ssel, b_burst, b_berr, b_serr, b_stall, b_sin, b_done, lim;
    b_ssel = ssel_cnt; b_burst = burst_cnt; b_berr = burst_err; b_serr = saddr_err;
    b_stall = stall_err; b_sin = sin_err; b_done = done_cnt; r_base_rd = rd_q.size();
    exp_saddr = a; abort = 0; r_to = 0; r_win_ssel = 0; lim = cyc + 3000;
    for (int i = 0; i < BS; i++) exp_rd[i] = ref_mem[a][i];
    @(posedge clk); #1; start = 1; addr = a;
    @(posedge clk); #1; start = 0; addr = 3'($urandom);
    fork
      begin : feed
        for (int i = 0; i < BS && !abort; i++) begin
          bit hs;
          int w0;
          if (i == in_stall_byte) begin
            in_valid = 0; hs = 0;
            while (!hs && !abort && cyc < lim) begin
              @(negedge clk); hs = in_ready; @(posedge clk); #1;
            end
            w0 = ssel_cnt;
            repeat (4) begin @(posedge clk); #1; end
            r_win_ssel = ssel_cnt - w0;
          end
          in_valid = 1; in_data = pat[i]; hs = 0;
          while (!hs && !abort && cyc < lim) begin
            @(negedge clk); hs = in_ready && !rst; @(posedge clk); #1;
          end
          in_valid = 0;
        end
        if (cyc >= lim) r_to = 1;
      end
      begin : ordy
        out_ready = 1;
        if (oready_after >= 0) begin
          while (rd_q.size() - r_base_rd < oready_after + 1 && !abort && cyc < lim) begin
            @(negedge clk); #1;
          end
          @(posedge clk); #1; out_ready = 0;
          repeat (oready_len) begin @(posedge clk); #1; end
          out_ready = 1;
        end
      end
      begin : spur
        if (spurious) begin
          repeat (30) begin @(posedge clk); #1; end
          start = 1; addr = 3'd5;
          @(posedge clk); #1; start = 0;
        end
      end
      begin : rstb
        if (abort_bits >= 0) begin
          while (ssel_cnt - b_ssel < abort_bits && cyc < lim) begin @(negedge clk); #1; end
          @(posedge clk); #2; rst = 1; #1;
          r_rst_ssel = ssel; r_rst_busy = busy; r_rst_ov = out_valid; abort = 1;
          repeat (2) @(posedge clk);
          @(negedge clk); rst = 0;
        end
      end
    join
    if (!abort) begin
      while (done_cnt == b_done && cyc < lim) begin @(negedge clk); #1; end
      if (cyc >= lim) r_to = 1;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < BS; i++) ref_mem[a][i] = pat[i];
      known[a] = 1;
    end else known[a] = 0;
    r_ssel = ssel_cnt - b_ssel; r_bursts = burst_cnt - b_burst; r_berr = burst_err - b_berr;
    r_serr = saddr_err - b_serr; r_stall = stall_err - b_stall; r_sinerr = sin_err - b_sin;
    r_done = done_cnt - b_done;
  endtask

  task automatic test_reset;
    rst = 1; load_chains = 1; start = 0; in_valid = 0; out_ready = 0; addr = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (ssel !== 1'b0 || sin !== 1'b0) begin failed++; $display("FAIL reset_scan got ssel=%b sin=%b want 0", ssel, sin); end
    tests++; if (saddr !== 3'd0 || out_data !== 8'd0) begin failed++; $display("FAIL reset_regs got saddr=%0d out_data=%h want 0", saddr, out_data); end
    load_chains = 0;
    @(negedge clk); rst = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    for (int i = 0; i < BS; i++) pat[i] = 8'(i);
    do_load(3'd3, -1, -1, 0, 0, -1);
    tests++; if (r_to) begin failed++; $display("FAIL t1_timeout got timeout want completion"); end
    tests++; if (r_ssel != CL || r_bursts != BS || r_berr != 0) begin failed++;
      $display("FAIL t1_ssel got cycles=%0d bursts=%0d badbursts=%0d want %0d/%0d/0", r_ssel, r_bursts, r_berr, CL, BS); end
    tests++; if (r_serr != 0 || r_sinerr != 0) begin failed++; $display("FAIL t1_saddr_sin got %0d/%0d errors want 0", r_serr, r_sinerr); end
    tests++; if (r_done != 1 || busy !== 1'b0) begin failed++; $display("FAIL t1_done got pulses=%0d busy=%b want 1/0", r_done, busy); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t1_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t1_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
    end
    tests++;
    begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && chains[3][CL-1-8*i -: 8] !== pat[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t1_chain3 byte %0d got %h want %h", bad, chains[3][CL-1-8*bad -: 8], pat[bad]); end
    end
  endtask

  task automatic test_reload;
    for (int i = 0; i < BS; i++) pat[i] = 8'hFF;
    do_load(3'd3, -1, -1, 0, 0, -1);
    tests++; if (r_to || r_done != 1) begin failed++; $display("FAIL t2_done got to=%b pulses=%0d want 0/1", r_to, r_done); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t2_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== 8'(i)) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t2_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], 8'(bad)); end
    end
    tests++;
    begin
      int bad = -1;
      for (int b = 0; b < NB; b++)
        if (known[b]) for (int i = 0; i < BS; i++)
          if (bad < 0 && chains[b][CL-1-8*i -: 8] !== ref_mem[b][i]) bad = b * 100 + i;
      if (bad >= 0) begin failed++; $display("FAIL t2_chains buf %0d byte %0d got %h want %h", bad / 100, bad % 100,
        chains[bad/100][CL-1-8*(bad%100) -: 8], ref_mem[bad/100][bad%100]); end
    end
  endtask

  task automatic test_in_stall;
    for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
    do_load(3'd1, 7, -1, 0, 0, -1);
    tests++; if (r_win_ssel != 0) begin failed++; $display("FAIL t3_stall_ssel got %0d shifts want 0", r_win_ssel); end
    tests++; if (r_ssel != CL || r_berr != 0 || r_done != 1) begin failed++;
      $display("FAIL t3_shifts got cycles=%0d badbursts=%0d done=%0d want %0d/0/1", r_ssel, r_berr, r_done, CL); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t3_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t3_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
    end
  endtask

  task automatic test_out_stall;
    for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
    do_load(3'd2, -1, 2, 10, 0, -1);
    tests++; if (r_stall != 0) begin failed++; $display("FAIL t4_stall got %0d cycles advancing while full want 0", r_stall); end
    tests++; if (r_ssel != CL || r_done != 1) begin failed++; $display("FAIL t4_shifts got cycles=%0d done=%0d want %0d/1", r_ssel, r_done, CL); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t4_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t4_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
    end
  endtask

  task automatic test_spurious_start;
    for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
    do_load(3'd3, -1, -1, 0, 1, -1);
    tests++; if (r_serr != 0 || saddr !== 3'd3) begin failed++; $display("FAIL t5_saddr got errs=%0d saddr=%0d want 0/3", r_serr, saddr); end
    tests++; if (r_done != 1 || busy !== 1'b0) begin failed++; $display("FAIL t5_done got pulses=%0d busy=%b want 1/0", r_done, busy); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t5_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t5_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
    end
  endtask

  task automatic test_reset_midload;
    for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
    do_load(3'd6, -1, -1, 0, 0, 5 * BW + 3);
    tests++; if (r_rst_ssel !== 1'b0 || r_rst_busy !== 1'b0 || r_rst_ov !== 1'b0) begin failed++;
      $display("FAIL t6_async got ssel=%b busy=%b out_valid=%b want 0", r_rst_ssel, r_rst_busy, r_rst_ov); end
    tests++; if (r_ssel != 5 * BW + 3 || r_done != 0) begin failed++;
      $display("FAIL t6_abort got shifts=%0d done=%0d want %0d/0", r_ssel, r_done, 5 * BW + 3); end
    tests++; if (saddr !== 3'd0 || out_data !== 8'd0) begin failed++; $display("FAIL t6_regs got saddr=%0d out_data=%h want 0", saddr, out_data); end
    for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
    do_load(3'd0, -1, -1, 0, 0, -1);
    tests++; if (r_to || r_done != 1 || r_ssel != CL) begin failed++;
      $display("FAIL t6_reload got to=%b done=%0d shifts=%0d want 0/1/%0d", r_to, r_done, r_ssel, CL); end
    tests++;
    if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL t6_rd_count got %0d want %0d", rd_q.size() - r_base_rd, BS); end
    else begin
      int bad = -1;
      for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin failed++; $display("FAIL t6_readback byte %0d got %h want %h", bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 5; n++) begin
      logic [2:0] a;
      bit chk;
      a = 3'($urandom);
      chk = known[a];
      for (int i = 0; i < BS; i++) pat[i] = 8'($urandom);
      do_load(a, int'($urandom_range(0, BS - 1)), int'($urandom_range(0, BS - 2)), int'($urandom_range(1, 15)), 0, -1);
      tests++; if (r_to || r_done != 1 || r_ssel != CL || r_stall != 0 || r_serr != 0) begin failed++;
        $display("FAIL b2b_%0d_ctrl got to=%b done=%0d shifts=%0d stall=%0d saddr_err=%0d", n, r_to, r_done, r_ssel, r_stall, r_serr); end
      tests++;
      if (rd_q.size() - r_base_rd != BS) begin failed++; $display("FAIL b2b_%0d_rd_count got %0d want %0d", n, rd_q.size() - r_base_rd, BS); end
      else if (chk) begin
        int bad = -1;
        for (int i = 0; i < BS; i++) if (bad < 0 && rd_q[r_base_rd+i] !== exp_rd[i]) bad = i;
        if (bad >= 0) begin failed++; $display("FAIL b2b_%0d_readback byte %0d got %h want %h", n, bad, rd_q[r_base_rd+bad], exp_rd[bad]); end
      end
    end
    tests++;
    begin
      int bad = -1;
      for (int b = 0; b < NB; b++)
        if (known[b]) for (int i = 0; i < BS; i++)
          if (bad < 0 && chains[b][CL-1-8*i -: 8] !== ref_mem[b][i]) bad = b * 100 + i;
      if (bad >= 0) begin failed++; $display("FAIL b2b_chains buf %0d byte %0d got %h want %h", bad / 100, bad % 100,
        chains[bad/100][CL-1-8*(bad%100) -: 8], ref_mem[bad/100][bad%100]); end
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      known[b] = 1;
      for (int i = 0; i < BS; i++) begin
        ref_mem[b][i] = 8'($urandom);
        init_bits[b][CL-1-8*i -: 8] = ref_mem[b][i];
      end
    end
    test_reset();
    test_basic();
    test_reload();
    test_in_stall();
    test_out_stall();
    test_spurious_start();
    test_reset_midload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion by cycle %0d want finish", cyc);
    $fatal(1);
  end

endmodule
